// File: rtl/exec_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : exec_issue_sched
// Function : Round-robin issue scheduler for the INT/MUL/DIV/MEM execution
//            FIFOs with common-data-bus slot reservation.
// Revision : 1.0  initial release
// ============================================================================
module exec_issue_sched #(
    parameter int LAT_INT = 1,
    parameter int LAT_MUL = 3,
    parameter int LAT_DIV = 6,
    parameter int LAT_MEM = 2,
    parameter int MAX_LAT = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_empty,
    input  logic       i_flush,
    output logic [3:0] o_rd_en,
    output logic       o_issue_valid,
    output logic [1:0] o_issue_unit,
    output logic       o_cdb_valid,
    output logic [1:0] o_cdb_sel,
    output logic       o_div_busy
);

    localparam int c_IW = $clog2(MAX_LAT + 1);
    localparam int c_DW = $clog2(LAT_DIV) + 1;

    // Entry k describes the result that will own the CDB k cycles from now.
    logic            r_res_vld  [0:MAX_LAT];
    logic [1:0]      r_res_unit [0:MAX_LAT];
    logic [1:0]      r_rr_ptr;
    logic [c_DW-1:0] r_div_cnt;

    logic [3:0]      w_elig;
    logic            w_found;
    logic [1:0]      w_win;
    logic [c_IW-1:0] w_slot;

    always_comb begin
        w_elig[0] = !i_empty[0] && !r_res_vld[LAT_INT];
        w_elig[1] = !i_empty[1] && !r_res_vld[LAT_MUL];
        w_elig[2] = !i_empty[2] && !r_res_vld[LAT_DIV] && (r_div_cnt == '0);
        w_elig[3] = !i_empty[3] && !r_res_vld[LAT_MEM];
        if (i_rst || i_flush) begin
            w_elig = 4'b0000;
        end
    end

    always_comb begin
        logic [1:0] w_idx;
        w_found = 1'b0;
        w_win   = 2'd0;
        w_idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_rr_ptr + 2'(k);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Slot written at the edge: one below the checked slot, since the array shifts.
    always_comb begin
        case (w_win)
            2'd0:    w_slot = c_IW'(LAT_INT - 1);
            2'd1:    w_slot = c_IW'(LAT_MUL - 1);
            2'd2:    w_slot = c_IW'(LAT_DIV - 1);
            default: w_slot = c_IW'(LAT_MEM - 1);
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            for (int k = 0; k <= MAX_LAT; k++) begin
                r_res_vld[k]  <= 1'b0;
                r_res_unit[k] <= 2'd0;
            end
            r_rr_ptr  <= 2'd0;
            r_div_cnt <= '0;
        end else begin
            for (int k = 0; k < MAX_LAT; k++) begin
                r_res_vld[k]  <= r_res_vld[k+1];
                r_res_unit[k] <= r_res_unit[k+1];
            end
            r_res_vld[MAX_LAT]  <= 1'b0;
            r_res_unit[MAX_LAT] <= 2'd0;
            if (w_found) begin
                r_res_vld[w_slot]  <= 1'b1;
                r_res_unit[w_slot] <= w_win;
                r_rr_ptr           <= w_win + 2'd1;
            end
            if (w_found && (w_win == 2'd2)) begin
                r_div_cnt <= c_DW'(LAT_DIV - 1);
            end else if (r_div_cnt != '0) begin
                r_div_cnt <= r_div_cnt - c_DW'(1);
            end
        end
    end

    always_comb begin
        o_rd_en = 4'b0000;
        if (w_found) begin
            o_rd_en[w_win] = 1'b1;
        end
    end

    assign o_issue_valid = w_found;
    assign o_issue_unit  = w_win;
    assign o_cdb_valid   = r_res_vld[0];
    assign o_cdb_sel     = r_res_unit[0];
    assign o_div_busy    = (r_div_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_exec_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_issue_sched
// Function : Self-checking bench for exec_issue_sched (vector table, directed
//            corner sequences and randomized traffic against a cycle model).
// Revision : 1.0  initial release
// ============================================================================
module tb_exec_issue_sched;

    logic       clk = 1'b1;
    logic       i_rst;
    logic [3:0] i_empty;
    logic       i_flush;
    logic [3:0] o_rd_en;
    logic       o_issue_valid;
    logic [1:0] o_issue_unit;
    logic       o_cdb_valid;
    logic [1:0] o_cdb_sel;
    logic       o_div_busy;

    always #5 clk = ~clk;

    exec_issue_sched dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_empty       (i_empty),
        .i_flush       (i_flush),
        .o_rd_en       (o_rd_en),
        .o_issue_valid (o_issue_valid),
        .o_issue_unit  (o_issue_unit),
        .o_cdb_valid   (o_cdb_valid),
        .o_cdb_sel     (o_cdb_sel),
        .o_div_busy    (o_div_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: absolute cycle numbers, a map of booked CDB cycles.
    int lat [4] = '{1, 3, 6, 2};
    int cyc = 0;
    int booked [int];
    int div_free_at = 0;
    int rr = 0;
    bit known = 0;
    bit m_found;
    int m_win;

    logic [3:0] s_rd_en;
    logic       s_cdb_valid;
    logic [1:0] s_cdb_sel;
    logic       s_busy;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] e, input logic f, input logic r);
        int exp_rd;
        i_empty = e;
        i_flush = f;
        i_rst   = r;
        @(negedge clk);
        m_found = 0;
        m_win   = 0;
        for (int k = 0; k < 4; k++) begin
            int q;
            q = (rr + k) % 4;
            if (!m_found && !e[q] && !f && !r && !booked.exists(cyc + lat[q]) &&
                (q != 2 || cyc >= div_free_at)) begin
                m_found = 1;
                m_win   = q;
            end
        end
        exp_rd = m_found ? (1 << m_win) : 0;
        s_rd_en     = o_rd_en;
        s_cdb_valid = o_cdb_valid;
        s_cdb_sel   = o_cdb_sel;
        s_busy      = o_div_busy;
        chk("m_rd_en", int'(o_rd_en), exp_rd);
        chk("m_issue_valid", int'(o_issue_valid), int'(m_found));
        chk("m_issue_unit", int'(o_issue_unit), m_win);
        if (known) begin
            chk("m_cdb_valid", int'(o_cdb_valid), booked.exists(cyc) ? 1 : 0);
            chk("m_cdb_sel", int'(o_cdb_sel), booked.exists(cyc) ? booked[cyc] : 0);
            chk("m_div_busy", int'(o_div_busy), (div_free_at > cyc) ? 1 : 0);
        end
        @(posedge clk);
        if (r || f) begin
            booked.delete();
            div_free_at = 0;
            rr = 0;
            if (r) known = 1;
        end else if (m_found) begin
            booked[cyc + lat[m_win]] = m_win;
            rr = (m_win + 1) % 4;
            if (m_win == 2) div_free_at = cyc + lat[2];
        end
        cyc++;
        #1;
    endtask

    typedef struct {
        logic [3:0] empty;
        logic       rst;
        logic [3:0] rd_en;
        logic       chk_cdb;
        logic       cdb_valid;
        logic [1:0] cdb_sel;
        logic       busy;
    } vec_t;

    vec_t vt [12];

    initial begin
        i_rst = 1'b1; i_flush = 1'b0; i_empty = 4'b1111;

        // Reset release with all FIFOs full, then drain.
        vt[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0};
        vt[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0};
        vt[2]  = '{4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b0};
        vt[3]  = '{4'b0000, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd0, 1'b0};
        vt[4]  = '{4'b0000, 1'b0, 4'b0100, 1'b1, 1'b0, 2'd0, 1'b0};
        vt[5]  = '{4'b0000, 1'b0, 4'b1000, 1'b1, 1'b0, 2'd0, 1'b1};
        vt[6]  = '{4'b0000, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1};
        vt[7]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b1};
        vt[8]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b1};
        vt[9]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1};
        vt[10] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b0};
        vt[11] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0};
        for (int i = 0; i < 12; i++) begin
            step(vt[i].empty, 1'b0, vt[i].rst);
            chk($sformatf("vec%0d_rd_en", i), int'(s_rd_en), int'(vt[i].rd_en));
            if (vt[i].chk_cdb) begin
                chk($sformatf("vec%0d_cdb_valid", i), int'(s_cdb_valid), int'(vt[i].cdb_valid));
                chk($sformatf("vec%0d_cdb_sel", i), int'(s_cdb_sel), int'(vt[i].cdb_sel));
                chk($sformatf("vec%0d_busy", i), int'(s_busy), int'(vt[i].busy));
            end
        end
        for (int i = 0; i < 6; i++) step(4'b1111, 1'b0, 1'b0);

        // CDB collision: MEM would land on MUL's slot and must wait a cycle.
        step(4'b1111, 1'b0, 1'b1);
        step(4'b1101, 1'b0, 1'b0); chk("col_mul_pop", int'(s_rd_en), 2);
        step(4'b0111, 1'b0, 1'b0); chk("col_mem_blocked", int'(s_rd_en), 0);
        step(4'b0111, 1'b0, 1'b0); chk("col_mem_pop", int'(s_rd_en), 8);
        step(4'b1111, 1'b0, 1'b0); chk("col_cdb_mul", int'(s_cdb_sel), 1);
        chk("col_cdb_mul_v", int'(s_cdb_valid), 1);
        step(4'b1111, 1'b0, 1'b0); chk("col_cdb_mem", int'(s_cdb_sel), 3);
        chk("col_cdb_mem_v", int'(s_cdb_valid), 1);

        // Back-to-back DIV: second pop exactly LAT_DIV cycles after the first.
        step(4'b1111, 1'b0, 1'b1);
        step(4'b1011, 1'b0, 1'b0); chk("div_pop0", int'(s_rd_en), 4);
        for (int i = 1; i < 6; i++) begin
            step(4'b1011, 1'b0, 1'b0);
            chk($sformatf("div_wait%0d", i), int'(s_rd_en), 0);
            chk($sformatf("div_busy%0d", i), int'(s_busy), 1);
        end
        step(4'b1011, 1'b0, 1'b0); chk("div_pop1", int'(s_rd_en), 4);
        chk("div_busy_clear", int'(s_busy), 0);
        for (int i = 0; i < 8; i++) step(4'b1111, 1'b0, 1'b0);

        // Flush with DIV and MUL in flight; reset overriding flush also applied.
        step(4'b1111, 1'b1, 1'b1);
        step(4'b1011, 1'b0, 1'b0); chk("fl_div_pop", int'(s_rd_en), 4);
        step(4'b1101, 1'b0, 1'b0); chk("fl_mul_pop", int'(s_rd_en), 2);
        step(4'b0000, 1'b1, 1'b0); chk("fl_no_pop", int'(s_rd_en), 0);
        step(4'b0000, 1'b0, 1'b0); chk("fl_rr_int", int'(s_rd_en), 1);
        chk("fl_busy", int'(s_busy), 0);
        chk("fl_cdb_dead", int'(s_cdb_valid), 0);
        for (int i = 0; i < 10; i++) begin
            step(4'b1111, 1'b0, 1'b0);
            chk($sformatf("idle_rd%0d", i), int'(s_rd_en), 0);
        end

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 99) == 0));
        end
        for (int i = 0; i < 12; i++) step(4'b1111, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
